// File: rtl/uart_tx_arbiter.sv
// Round-robin owner selection for one shared UART TX serializer.
// Ports: REQ_* per-requester byte streams; TX_* serializer handshake; GRANT/ACTIVE owner status.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DW           = 8,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [N_REQ-1:0]    REQ_VALID,
  input  logic [N_REQ*DW-1:0] REQ_DATA,
  input  logic [N_REQ-1:0]    REQ_LAST,
  output logic [N_REQ-1:0]    REQ_READY,
  output logic [DW-1:0]       TX_DATA,
  output logic                TX_START,
  input  logic                TX_BUSY,
  output logic [N_REQ-1:0]    GRANT,
  output logic                ACTIVE
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam int TW = $clog2(HOLD_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    own_q, own_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             last_q, last_d;
  logic [DW-1:0]    txd_q, txd_d;
  logic             start_q, start_d;

  logic [IW-1:0]    pick;
  logic             found;
  logic [DW-1:0]    sel_data;
  logic             sel_valid;
  logic             sel_last;

  // First valid requester after the last released owner, with wrap.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [IW-1:0] jj;
      jj = IW'((int'(ptr_q) + k) % N_REQ);
      if (!found && REQ_VALID[jj]) begin
        found = 1'b1;
        pick  = jj;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (own_q == IW'(i)) sel_data = REQ_DATA[i*DW +: DW];
    end
  end

  assign sel_valid = |(REQ_VALID & grant_q);
  assign sel_last  = |(REQ_LAST & grant_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    grant_d   = grant_q;
    burst_d   = burst_q;
    tmo_d     = tmo_q;
    last_d    = last_q;
    txd_d     = txd_q;
    start_d   = 1'b0;
    REQ_READY = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          own_d         = pick;
          burst_d       = '0;
          tmo_d         = '0;
          state_d       = S_SEND;
        end
      end
      S_SEND: begin
        REQ_READY = grant_q & {N_REQ{~TX_BUSY}};
        if (sel_valid && !TX_BUSY) begin
          txd_d   = sel_data;
          start_d = 1'b1;
          last_d  = sel_last;
          burst_d = burst_q + BW'(1);
          tmo_d   = '0;
          state_d = S_WAIT_BUSY;
        end else if (!sel_valid) begin
          // Release on the cycle the count would reach the limit.
          if (tmo_q + TW'(1) == TW'(HOLD_TIMEOUT)) begin
            ptr_d   = own_q;
            grant_d = '0;
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      S_WAIT_BUSY: begin
        if (TX_BUSY) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!TX_BUSY) begin
          if (last_q || burst_q == BW'(MAX_BURST)) begin
            ptr_d   = own_q;
            grant_d = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      own_q   <= '0;
      grant_q <= '0;
      burst_q <= '0;
      tmo_q   <= '0;
      last_q  <= 1'b0;
      txd_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      tmo_q   <= tmo_d;
      last_q  <= last_d;
      txd_q   <= txd_d;
      start_q <= start_d;
    end
  end

  assign TX_DATA  = txd_q;
  assign TX_START = start_q;
  assign GRANT    = grant_q;
  assign ACTIVE   = |grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: random packets, packet-level
// round-robin model, serializer model, reset/timeout/busy directed phases.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int HT = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [N-1:0]  REQ_VALID = '0;
  logic [N*DW-1:0] REQ_DATA = '0;
  logic [N-1:0]  REQ_LAST = '0;
  logic [N-1:0]  REQ_READY;
  logic [DW-1:0] TX_DATA;
  logic          TX_START;
  logic          TX_BUSY = 1'b0;
  logic [N-1:0]  GRANT;
  logic          ACTIVE;

  uart_tx_arbiter #(
    .N_REQ(N), .DW(DW), .MAX_BURST(MB), .HOLD_TIMEOUT(HT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
    .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY),
    .TX_DATA(TX_DATA), .TX_START(TX_START),
    .TX_BUSY(TX_BUSY), .GRANT(GRANT), .ACTIVE(ACTIVE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } byte_t;

  typedef struct packed {
    logic [1:0] req;
    logic [7:0] data;
  } exp_t;

  byte_t dq[N][$];
  byte_t mq[N][$];
  exp_t  expq[$];

  int   mptr = N - 1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   pend = -1;
  int   bcnt = 0;
  int   extra = 0;
  logic busy_q = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    byte_t b;
    b.last = l;
    b.data = d;
    dq[r].push_back(b);
    mq[r].push_back(b);
  endtask

  // Packet-level arbitration: next non-empty requester after ptr takes
  // bytes until LAST, burst limit, or its stream runs dry (timeout).
  function automatic void plan();
    int    g;
    int    cnt;
    byte_t b;
    exp_t  e;
    while (1) begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (mptr + k) % N;
        if (g < 0 && mq[j].size() > 0) g = j;
      end
      if (g < 0) break;
      cnt = 0;
      while (mq[g].size() > 0) begin
        b = mq[g].pop_front();
        e.req = 2'(g);
        e.data = b.data;
        expq.push_back(e);
        cnt++;
        if (b.last || cnt == MB) break;
      end
      mptr = g;
    end
  endfunction

  function automatic bit all_empty();
    bit r;
    r = 1'b1;
    for (int i = 0; i < N; i++) if (dq[i].size() > 0) r = 1'b0;
    return r;
  endfunction

  // Requester drivers and serializer model.
  initial begin : drv
    logic [N-1:0] hs;
    logic         st;
    forever begin
      @(negedge CLK);
      hs = REQ_VALID & REQ_READY;
      st = TX_START;
      @(posedge CLK);
      #1;
      for (int i = 0; i < N; i++)
        if (hs[i] && dq[i].size() > 0) dq[i].delete(0);
      if (pend == 0) begin
        busy_q = 1'b1;
        bcnt = $urandom_range(3, 8);
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end else if (busy_q) begin
        bcnt--;
        if (bcnt == 0) busy_q = 1'b0;
      end
      if (st) pend = $urandom_range(0, 2);
      TX_BUSY = busy_q || (extra > 0);
      if (extra > 0) extra--;
      for (int i = 0; i < N; i++) begin
        REQ_VALID[i] = dq[i].size() > 0;
        REQ_DATA[i*DW +: DW] = (dq[i].size() > 0) ? dq[i][0].data : 8'h00;
        REQ_LAST[i] = (dq[i].size() > 0) ? dq[i][0].last : 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each launched frame.
  initial begin : mon
    logic [N-1:0] hs_p;
    logic [N-1:0] g_p;
    logic         st_p;
    exp_t         e;
    hs_p = '0;
    g_p = '0;
    st_p = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        hs_p = '0;
        g_p = '0;
        st_p = 1'b0;
      end else begin
        if (TX_START) begin
          chk("start_expected", expq.size() != 0, 1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("tx_data", TX_DATA, e.data);
            chk("tx_grant", GRANT, 32'd1 << e.req);
          end
          chk("start_one_cycle", st_p, 0);
        end
        if (TX_START || (|hs_p)) chk("start_follows_xfer", TX_START, |hs_p);
        chk("active", ACTIVE, |GRANT);
        chk("grant_onehot0", $onehot0(GRANT), 1);
        chk("ready_legal", REQ_READY & ~(GRANT & {N{~TX_BUSY}}), 0);
        if (GRANT != g_p && GRANT != 0) chk("idle_gap", g_p, 0);
        hs_p = REQ_VALID & REQ_READY;
        st_p = TX_START;
        g_p = GRANT;
      end
    end
  end

  task automatic drain(input string nm);
    int t;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!(expq.size() == 0 && all_empty() && GRANT == 0 &&
                 !TX_BUSY && pend < 0 && extra == 0) && t < 5000);
    chk({nm, "_drain"}, t < 5000, 1);
    chk({nm, "_left"}, expq.size(), 0);
  endtask

  initial begin : main
    int t;
    int n0;
    int n1;
    #1;
    chk("rst_grant", GRANT, 0);
    chk("rst_active", ACTIVE, 0);
    chk("rst_start", TX_START, 0);
    chk("rst_data", TX_DATA, 0);
    chk("rst_ready", REQ_READY, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    @(negedge CLK);
    push(2, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b0);
    push(2, 8'hA3, 1'b1);
    plan();
    drain("single");

    @(negedge CLK);
    for (int k = 0; k < 10; k++) push(1, 8'($urandom), 1'b0);
    push(2, 8'($urandom), 1'b0);
    push(2, 8'($urandom), 1'b1);
    plan();
    drain("burst");

    @(negedge CLK);
    for (int rep = 0; rep < 2; rep++) begin
      push(0, 8'($urandom), 1'b1);
      push(1, 8'($urandom), 1'b1);
      push(3, 8'($urandom), 1'b1);
    end
    plan();
    drain("rr");

    for (int ph = 0; ph < 6; ph++) begin
      @(negedge CLK);
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 3) != 0) begin
          int np;
          np = $urandom_range(1, 2);
          for (int p = 0; p < np; p++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++)
              push(r, 8'($urandom), b == len - 1);
          end
        end
      end
      plan();
      drain("rand");
    end

    @(negedge CLK);
    extra = 6;
    push(1, 8'($urandom), 1'b0);
    push(1, 8'($urandom), 1'b1);
    plan();
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!(GRANT == 4'b0010 && !TX_BUSY) && t < 200);
    chk("busy_wait", t < 200, 1);
    chk("ready_after_busy", REQ_READY, 4'b0010);
    drain("busy");

    @(negedge CLK);
    for (int r = 0; r < N; r++)
      for (int b = 0; b < 3; b++) push(r, 8'($urandom), b == 2);
    plan();
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!(TX_BUSY && GRANT != 0) && t < 500);
    chk("rst_wait", t < 500, 1);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_grant", GRANT, 0);
    chk("mid_rst_active", ACTIVE, 0);
    chk("mid_rst_start", TX_START, 0);
    chk("mid_rst_data", TX_DATA, 0);
    chk("mid_rst_ready", REQ_READY, 0);
    @(negedge CLK);
    for (int r = 0; r < N; r++) begin
      dq[r].delete();
      mq[r].delete();
    end
    expq.delete();
    busy_q = 1'b0;
    pend = -1;
    extra = 0;
    mptr = N - 1;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    @(negedge CLK);
    push(0, 8'($urandom), 1'b0);
    push(3, 8'($urandom), 1'b0);
    push(3, 8'($urandom), 1'b1);
    plan();
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!(TX_START && GRANT == 4'b0001) && t < 200);
    while (!TX_BUSY && t < 400) begin
      @(negedge CLK);
      t++;
    end
    while (TX_BUSY && t < 600) begin
      @(negedge CLK);
      t++;
    end
    n0 = cyc;
    while (GRANT != 0 && t < 800) begin
      @(negedge CLK);
      t++;
    end
    n1 = cyc;
    chk("tmo_wait", t < 800, 1);
    chk("tmo_cycles", n1 - n0, 9);
    drain("tmo");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
